// File: rtl/obstacle_nav_ctrl.sv
// Obstacle-avoidance motor sequencer: confirms obstacle codes, then runs brake/reverse/turn.
// Optional: define ALTERNATE_TURN_EN to alternate turn direction on successive manoeuvres.
module obstacle_nav_ctrl #(
   parameter int unsigned SAMPLE_PERIOD = 30000000,
   parameter int unsigned CONFIRM_N     = 2,
   parameter int unsigned BRAKE_TICKS   = 10000000,
   parameter int unsigned REVERSE_TICKS = 50000000,
   parameter int unsigned TURN_TICKS    = 40000000,
   parameter int unsigned PWM_PERIOD    = 100000,
   parameter int unsigned PWM_DUTY      = 60000
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       enable,
   input  logic [1:0] choose,
   output logic [1:0] motor_l,
   output logic [1:0] motor_r,
   output logic       pwm,
   output logic [2:0] state,
   output logic [7:0] avoid_count
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StForward = 3'd1,
      StBrake   = 3'd2,
      StReverse = 3'd3,
      StTurn    = 3'd4
   } state_e;

   localparam logic [25:0] SampleLast  = 26'(SAMPLE_PERIOD - 1);
   localparam logic [25:0] BrakeLast   = 26'(BRAKE_TICKS - 1);
   localparam logic [25:0] ReverseLast = 26'(REVERSE_TICKS - 1);
   localparam logic [25:0] TurnLast    = 26'(TURN_TICKS - 1);
   localparam logic [16:0] PwmLast     = 17'(PWM_PERIOD - 1);
   localparam logic [3:0]  ConfirmN    = 4'(CONFIRM_N);

   state_e      state_q, state_d;
   logic [25:0] samp_cnt_q, samp_cnt_d;
   logic [25:0] timer_q, timer_d;
   logic [16:0] pwm_cnt_q, pwm_cnt_d;
   logic [3:0]  conf_q, conf_d, conf_upd;
   logic [7:0]  avoid_q, avoid_d;
   logic [1:0]  motor_l_q, motor_l_d;
   logic [1:0]  motor_r_q, motor_r_d;
   logic        pwm_q, pwm_d;
   logic        tick;
   logic        turn_left;

   assign tick = (samp_cnt_q == SampleLast);

   always_comb begin
      samp_cnt_d = tick ? '0 : samp_cnt_q + 26'd1;
      pwm_cnt_d  = (pwm_cnt_q == PwmLast) ? '0 : pwm_cnt_q + 17'd1;
   end

   // Anything but an explicit "clear" code counts as an obstacle (fail-safe).
   always_comb begin
      conf_upd = conf_q;
      if (state_q == StForward && tick) begin
         if (choose == 2'b10) begin
            conf_upd = '0;
         end else if (conf_q < ConfirmN) begin
            conf_upd = conf_q + 4'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    state_d = StForward;
         StForward: if (tick && conf_upd == ConfirmN) state_d = StBrake;
         StBrake:   if (timer_q == BrakeLast) state_d = StReverse;
         StReverse: if (timer_q == ReverseLast) state_d = StTurn;
         StTurn:    if (timer_q == TurnLast) state_d = StForward;
         default:   state_d = StIdle;
      endcase
      if (!enable) begin
         state_d = StIdle;
      end
   end

   always_comb begin
      conf_d  = (state_d == StForward) ? conf_upd : '0;
      timer_d = (state_d != state_q) ? '0 : timer_q + 26'd1;
      avoid_d = avoid_q;
      if (state_q == StForward && state_d == StBrake && avoid_q != 8'hFF) begin
         avoid_d = avoid_q + 8'd1;
      end
   end

`ifdef ALTERNATE_TURN_EN
   logic turn_left_q, turn_left_d;

   always_comb begin
      turn_left_d = turn_left_q;
      if (state_d == StIdle) begin
         turn_left_d = 1'b0;
      end else if (state_q == StTurn && state_d == StForward) begin
         turn_left_d = ~turn_left_q;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         turn_left_q <= 1'b0;
      end else begin
         turn_left_q <= turn_left_d;
      end
   end

   assign turn_left = turn_left_q;
`else
   assign turn_left = 1'b0;
`endif

   // Outputs decode the next state so they change on the same edge as state.
   always_comb begin
      motor_l_d = 2'b00;
      motor_r_d = 2'b00;
      case (state_d)
         StForward: begin
            motor_l_d = 2'b01;
            motor_r_d = 2'b01;
         end
         StReverse: begin
            motor_l_d = 2'b10;
            motor_r_d = 2'b10;
         end
         StTurn: begin
            motor_l_d = turn_left ? 2'b10 : 2'b01;
            motor_r_d = turn_left ? 2'b01 : 2'b10;
         end
         default: begin
            motor_l_d = 2'b00;
            motor_r_d = 2'b00;
         end
      endcase
      pwm_d = ({15'd0, pwm_cnt_q} < PWM_DUTY) &&
              (state_d == StForward || state_d == StReverse || state_d == StTurn);
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q    <= StIdle;
         samp_cnt_q <= '0;
         timer_q    <= '0;
         pwm_cnt_q  <= '0;
         conf_q     <= '0;
         avoid_q    <= '0;
         motor_l_q  <= 2'b00;
         motor_r_q  <= 2'b00;
         pwm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         samp_cnt_q <= samp_cnt_d;
         timer_q    <= timer_d;
         pwm_cnt_q  <= pwm_cnt_d;
         conf_q     <= conf_d;
         avoid_q    <= avoid_d;
         motor_l_q  <= motor_l_d;
         motor_r_q  <= motor_r_d;
         pwm_q      <= pwm_d;
      end
   end

   assign state       = state_q;
   assign motor_l     = motor_l_q;
   assign motor_r     = motor_r_q;
   assign pwm         = pwm_q;
   assign avoid_count = avoid_q;

endmodule

// File: tb/tb_obstacle_nav_ctrl.sv
// Directed bench for obstacle_nav_ctrl using small timing parameters.
module tb_obstacle_nav_ctrl;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [1:0] choose;
   logic [1:0] motor_l;
   logic [1:0] motor_r;
   logic       pwm;
   logic [2:0] state;
   logic [7:0] avoid_count;

   int checks = 0;
   int errors = 0;
   int edge_n;

   localparam logic [3:0] TurnRight = 4'b0110;
   localparam logic [3:0] TurnLeft  = 4'b1001;

   obstacle_nav_ctrl #(
      .SAMPLE_PERIOD(10),
      .CONFIRM_N    (2),
      .BRAKE_TICKS  (5),
      .REVERSE_TICKS(8),
      .TURN_TICKS   (6),
      .PWM_PERIOD   (4),
      .PWM_DUTY     (2)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .enable     (enable),
      .choose     (choose),
      .motor_l    (motor_l),
      .motor_r    (motor_r),
      .pwm        (pwm),
      .state      (state),
      .avoid_count(avoid_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; sample ticks land on multiples of 10, pwm period is 4.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_pwm(input int n);
      return ((n - 1) % 4) < 2;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_to(input int n);
      while (edge_n < n) step();
   endtask

   function automatic logic [31:0] outs();
      return 32'({state, motor_l, motor_r, pwm});
   endfunction

   task automatic chk_fwd(input string tag);
      check(tag, outs(), 32'({3'd1, 4'b0101, exp_pwm(edge_n)}));
   endtask

   task automatic chk_brake_entry(input string tag, input logic [7:0] exp_avoid);
      check(tag, outs(), 32'({3'd2, 4'b0000, 1'b0}));
      check({tag, "_cnt"}, 32'(avoid_count), 32'(exp_avoid));
   endtask

   // Called just after the BRAKE entry edge; follows the 19 edges back to FORWARD.
   task automatic run_manoeuvre(input logic [3:0] turn_m);
      for (int k = 1; k <= 19; k++) begin
         logic [2:0] s;
         logic [3:0] m;
         step();
         if (k < 5)       begin s = 3'd2; m = 4'b0000; end
         else if (k < 13) begin s = 3'd3; m = 4'b1010; end
         else if (k < 19) begin s = 3'd4; m = turn_m;  end
         else             begin s = 3'd1; m = 4'b0101; end
         check("manv", outs(), 32'({s, m, (s != 3'd2) && exp_pwm(edge_n)}));
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (state != s && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(state), 32'(s));
   endtask

   initial begin
      logic [3:0] second_turn;
`ifdef ALTERNATE_TURN_EN
      second_turn = TurnLeft;
`else
      second_turn = TurnRight;
`endif
      rst_n  = 1'b0;
      enable = 1'b0;
      choose = 2'b10;
      repeat (3) step();
      check("rst_outs", outs(), 32'd0);
      check("rst_avoid", 32'(avoid_count), 32'd0);
      #2 rst_n = 1'b1;

      step_to(2);
      check("idle_outs", outs(), 32'd0);
      check("idle_avoid", 32'(avoid_count), 32'd0);

      // Enable and present an obstacle: ticks at edges 10 and 20.
      enable = 1'b1;
      choose = 2'b01;
      for (int n = 3; n <= 9; n++) begin
         step_to(n);
         chk_fwd("fwd_pwm");
      end
      step_to(10);
      chk_fwd("tick1");
      step_to(19);
      chk_fwd("pre_brake");
      step_to(20);
      chk_brake_entry("brake1", 8'd1);
      choose = 2'b10;
      run_manoeuvre(TurnRight);

      // 01, 10, 01 on successive ticks must not start a manoeuvre.
      choose = 2'b01;
      step_to(40);
      chk_fwd("pat_01a");
      choose = 2'b10;
      step_to(50);
      chk_fwd("pat_10");
      choose = 2'b01;
      step_to(60);
      chk_fwd("pat_01b");
      choose = 2'b10;
      step_to(70);
      chk_fwd("pat_clr");
      check("pat_avoid", 32'(avoid_count), 32'd1);

      // Invalid code 11 counts as obstacle.
      choose = 2'b11;
      step_to(80);
      chk_fwd("c11_tick1");
      step_to(90);
      chk_brake_entry("brake_c11", 8'd2);
      choose = 2'b10;
      run_manoeuvre(second_turn);

      // Drop enable three cycles into REVERSE.
      choose = 2'b01;
      step_to(120);
      chk_brake_entry("brake3", 8'd3);
      step_to(127);
      check("in_rev", 32'(state), 32'd3);
      enable = 1'b0;
      step_to(128);
      check("dis_idle", outs(), 32'd0);
      step_to(129);
      enable = 1'b1;
      step_to(130);
      chk_fwd("reen_fwd");
      step_to(140);
      chk_fwd("reen_tick1");
      step_to(141);
      enable = 1'b0;
      step_to(142);
      check("dis2_idle", outs(), 32'd0);
      enable = 1'b1;
      step_to(143);
      chk_fwd("reen2_fwd");
      step_to(150);
      chk_fwd("conf_cleared");
      step_to(160);
      chk_brake_entry("brake4", 8'd4);

      // Asynchronous reset in the middle of TURN.
      step_to(175);
      check("in_turn", outs(), 32'({3'd4, TurnRight, exp_pwm(edge_n)}));
      #2 rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check("arst_outs", outs(), 32'd0);
      check("arst_avoid", 32'(avoid_count), 32'd0);
      repeat (2) step();
      #2 rst_n = 1'b1;
      step_to(2);
      check("post_rst_idle", outs(), 32'd0);

      // Back-to-back manoeuvres until avoid_count saturates.
      enable = 1'b1;
      choose = 2'b01;
      for (int m = 1; m <= 257; m++) begin
         wait_state(3'd1, 40, "sat_fwd");
         wait_state(3'd2, 40, "sat_brake");
         if (m <= 2) begin
            repeat (13) step();
            check("sat_turn", 32'({state, motor_l, motor_r}),
                  32'({3'd4, (m == 1) ? TurnRight : second_turn}));
         end
         if (m == 1)   check("sat_cnt1", 32'(avoid_count), 32'd1);
         if (m == 100) check("sat_cnt100", 32'(avoid_count), 32'd100);
         if (m == 255) check("sat_cnt255", 32'(avoid_count), 32'd255);
         if (m == 257) check("sat_cnt257", 32'(avoid_count), 32'd255);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/obstacle_nav_ctrl.md
Name: obstacle_nav_ctrl

Overview:
- Downstream consumer of the ultrasonic ranging stage's 2-bit obstacle code `choose`. 01 means obstacle near; 10 means path clear.
- Samples the code once per measurement period and requires consecutive obstacle readings before acting.
- Drives differential-drive motor direction codes and a shared PWM enable through a timed avoidance manoeuvre: brake, reverse, turn, resume forward.
- Sits between the ranging stage and the motor driver pins.

Parameters:
- SAMPLE_PERIOD, 30000000: clocks between choose samples; matches the ranging loop (300 ms at 100 MHz).
- CONFIRM_N, 2: consecutive non-clear samples required to start avoidance; legal range 1..15.
- BRAKE_TICKS, 10000000: clocks spent in BRAKE.
- REVERSE_TICKS, 50000000: clocks spent in REVERSE.
- TURN_TICKS, 40000000: clocks spent in TURN.
- PWM_PERIOD, 100000: PWM period in clocks (1 kHz).
- PWM_DUTY, 60000: PWM high clocks per period.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz
- CPU_RESETN  in  1  asynchronous active-low reset
- enable  in  1  run request; 0 forces IDLE
- choose  in  2  obstacle code from ranging stage, same clock domain
- motor_l  out  2  left motor direction: 00 stop, 01 forward, 10 reverse
- motor_r  out  2  right motor direction, same encoding
- pwm  out  1  motor speed enable, shared by both motors
- state  out  3  current state: IDLE=0, FORWARD=1, BRAKE=2, REVERSE=3, TURN=4
- avoid_count  out  8  manoeuvres started, saturating at 255

Behaviour:
- Reset is asynchronous and active-low on CPU_RESETN. All state is clocked on the rising edge of CLK100MHZ.
- Reset values:
  - state=IDLE; motor_l=motor_r=00; pwm=0; avoid_count=0.
  - Sample counter, phase timer, PWM counter and confirm counter all 0.
  - Turn-direction flag=0 (right).
- Sample tick:
  - Counter is 26 bits and free-running in all states; counts 0..SAMPLE_PERIOD-1 and wraps.
  - A one-cycle tick fires in the cycle where count==SAMPLE_PERIOD-1.
- Confirm counter (4 bits):
  - Held at 0 whenever state!=FORWARD.
  - In FORWARD, on a tick: choose==10 clears it. Any other value (01, 00, 11) increments it, saturating at CONFIRM_N. Invalid codes are treated as obstacle (fail-safe).
- Phase timer:
  - 26 bits; cleared on entry to BRAKE, REVERSE and TURN; increments each cycle.
  - A phase with parameter X exits in the cycle where timer==X-1, so the state lasts exactly X cycles.
- Transitions:
  - Any state -> IDLE when enable=0; takes effect at the next edge and has priority over all other transitions.
  - IDLE -> FORWARD when enable=1.
  - FORWARD -> BRAKE on a tick where the post-update confirm count equals CONFIRM_N. On this edge avoid_count increments (holds at 255).
  - BRAKE -> REVERSE after BRAKE_TICKS cycles.
  - REVERSE -> TURN after REVERSE_TICKS cycles.
  - TURN -> FORWARD after TURN_TICKS cycles.
  - choose is ignored outside FORWARD.
- Motor outputs are registered and updated on the same edge as state, so outputs reflect the new state with 0 extra latency relative to `state`:
  - IDLE and BRAKE: 00/00.
  - FORWARD: 01/01.
  - REVERSE: 10/10.
  - TURN right: motor_l=01, motor_r=10.
  - TURN left: motor_l=10, motor_r=01.
- PWM:
  - Counter is 17 bits, free-running 0..PWM_PERIOD-1, not reset by state changes.
  - pwm is registered: pwm = (pwm_cnt < PWM_DUTY) AND next state in {FORWARD, REVERSE, TURN}.
  - PWM_DUTY>=PWM_PERIOD gives constant high while moving; PWM_DUTY=0 gives constant low.
- Reset mid-manoeuvre: immediately forces all reset values. After release, the block waits for enable in IDLE.
- enable deassert and reassert mid-manoeuvre: the block restarts in FORWARD with the confirm counter at 0. The manoeuvre is not resumed.

Optional Feature:
- Macro: ALTERNATE_TURN_EN.
- Defined: the turn-direction flag toggles on every TURN->FORWARD transition, so successive manoeuvres alternate right, left, right, and so on. Reset and forced IDLE both return the flag to right.
- Undefined: no flag register is present; TURN is always right (01/10).

Test Plan:
- Bench parameters for all scenarios: SAMPLE_PERIOD=10, CONFIRM_N=2, BRAKE_TICKS=5, REVERSE_TICKS=8, TURN_TICKS=6, PWM_PERIOD=4, PWM_DUTY=2.
- Hold CPU_RESETN=0 then release with enable=0 -> state=0, motors 00/00, pwm=0, avoid_count=0. Raise enable -> state=1, motors 01/01 one edge later; pwm toggles 2 high / 2 low.
- choose=01 held through two ticks -> BRAKE entered on the second tick edge; avoid_count=1. Then BRAKE holds 5 cycles, REVERSE (10/10) 8 cycles, TURN (01/10) 6 cycles, then FORWARD.
- Pattern 01, 10, 01 on successive ticks -> no BRAKE; confirm counter cleared by the 10 sample.
- choose=11 on two ticks -> avoidance starts (fail-safe).
- enable dropped 3 cycles into REVERSE -> state=0, motors 00/00, pwm=0 next edge. Re-enable -> FORWARD with confirm counter 0. Assert CPU_RESETN low mid-TURN -> all outputs at reset values asynchronously.
- Run 257 manoeuvres -> avoid_count saturates at 255. With ALTERNATE_TURN_EN defined, TURN directions alternate 01/10 then 10/01.
